// File: rtl/phy_cmd_issue.sv
// Single-bank DRAM command issuer: accepts NOP/ACT/RD/WR/PRE/REF, enforces the
// bank timing windows and drives the registered DRAM command pins.
module phy_cmd_issue #(
  parameter int T_RCD = 6,
  parameter int T_RP  = 6,
  parameter int T_RAS = 15,
  parameter int T_CCD = 4,
  parameter int T_WTP = 12,
  parameter int T_RFC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  input  logic [2:0]  i_cmd,
  input  logic [2:0]  i_ba,
  input  logic [15:0] i_addr,
  output logic        o_cmd_ready,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [2:0]  ba,
  output logic [15:0] addr,
  output logic        o_bank_open,
  output logic [15:0] o_open_row,
  output logic        o_cmd_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a command transfers on a rising edge where i_cmd_valid && o_cmd_ready;
  // o_cmd_ready depends only on i_cmd, bank state and timers, never on i_cmd_valid.

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  localparam logic [3:0] PIN_NOP = 4'b0111;
  localparam logic [3:0] PIN_ACT = 4'b0011;
  localparam logic [3:0] PIN_RD  = 4'b0101;
  localparam logic [3:0] PIN_WR  = 4'b0100;
  localparam logic [3:0] PIN_PRE = 4'b0010;
  localparam logic [3:0] PIN_REF = 4'b0001;

  localparam int TW = 16;
  localparam logic [TW-1:0] LD_RCD = TW'(T_RCD - 1);
  localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);
  localparam logic [TW-1:0] LD_RAS = TW'(T_RAS - 1);
  localparam logic [TW-1:0] LD_CCD = TW'(T_CCD - 1);
  localparam logic [TW-1:0] LD_WTP = TW'(T_WTP - 1);
  localparam logic [TW-1:0] LD_RFC = TW'(T_RFC - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   trcd_q, trcd_d, trp_q, trp_d, tras_q, tras_d;
  logic [TW-1:0]   tccd_q, tccd_d, twtp_q, twtp_d, trfc_q, trfc_d;
  logic [3:0]      pins_q, pins_d;
  logic [2:0]      ba_q, ba_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     open_row_q, open_row_d;
  logic            err_q, err_d;

  logic            rdy, legal, illegal, accept, issue;
  logic [15:0]     col_addr;

  function automatic logic [TW-1:0] tdec(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  // Column address: BL8 on A12, auto-precharge off on A10.
  assign col_addr = {i_addr[15:13], 1'b1, i_addr[11], 1'b0, i_addr[9:0]};

  always_comb begin
    rdy     = 1'b0;
    legal   = 1'b0;
    illegal = 1'b0;
    case (i_cmd)
      CMD_NOP: rdy = 1'b1;
      CMD_ACT, CMD_REF: begin
        if (state_q == ST_CLOSED) begin
          rdy   = (trp_q == '0);
          legal = rdy;
        end else if (state_q == ST_OPEN) begin
          rdy     = 1'b1;
          illegal = 1'b1;
        end
      end
      CMD_RD, CMD_WR: begin
        if (state_q == ST_OPEN) begin
          rdy   = (trcd_q == '0) && (tccd_q == '0);
          legal = rdy;
        end else if (state_q == ST_CLOSED) begin
          rdy     = 1'b1;
          illegal = 1'b1;
        end
      end
      CMD_PRE: begin
        if (state_q == ST_OPEN) begin
          rdy   = (tras_q == '0) && (twtp_q == '0);
          legal = rdy;
        end else if (state_q == ST_CLOSED) begin
          rdy   = (trp_q == '0);
          legal = rdy;
        end
      end
      default: begin
        if (state_q != ST_REFRESH) begin
          rdy     = 1'b1;
          illegal = 1'b1;
        end
      end
    endcase
  end

  assign o_cmd_ready = rdy && !rst;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign issue       = accept && legal;

  always_comb begin
    state_d    = state_q;
    open_row_d = open_row_q;
    pins_d     = PIN_NOP;
    ba_d       = 3'd0;
    addr_d     = 16'd0;
    err_d      = accept && illegal;
    trcd_d     = tdec(trcd_q);
    trp_d      = tdec(trp_q);
    tras_d     = tdec(tras_q);
    tccd_d     = tdec(tccd_q);
    twtp_d     = tdec(twtp_q);
    trfc_d     = tdec(trfc_q);
    if (issue) begin
      ba_d = i_ba;
      case (i_cmd)
        CMD_ACT: begin
          pins_d     = PIN_ACT;
          addr_d     = i_addr;
          trcd_d     = LD_RCD;
          tras_d     = LD_RAS;
          state_d    = ST_OPEN;
          open_row_d = i_addr;
        end
        CMD_RD: begin
          pins_d = PIN_RD;
          addr_d = col_addr;
          tccd_d = LD_CCD;
        end
        CMD_WR: begin
          pins_d = PIN_WR;
          addr_d = col_addr;
          tccd_d = LD_CCD;
          twtp_d = LD_WTP;
        end
        CMD_PRE: begin
          pins_d  = PIN_PRE;
          trp_d   = LD_RP;
          state_d = ST_CLOSED;
        end
        CMD_REF: begin
          pins_d  = PIN_REF;
          trfc_d  = LD_RFC;
          state_d = ST_REFRESH;
        end
        default: ba_d = 3'd0;
      endcase
    end
    // Leave REFRESH on the edge where tRFC reaches zero so the next command can issue right after.
    if (state_q == ST_REFRESH && trfc_q <= TW'(1))
      state_d = ST_CLOSED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLOSED;
      trcd_q     <= '0;
      trp_q      <= '0;
      tras_q     <= '0;
      tccd_q     <= '0;
      twtp_q     <= '0;
      trfc_q     <= '0;
      pins_q     <= 4'b1111;
      ba_q       <= 3'd0;
      addr_q     <= 16'd0;
      open_row_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      trcd_q     <= trcd_d;
      trp_q      <= trp_d;
      tras_q     <= tras_d;
      tccd_q     <= tccd_d;
      twtp_q     <= twtp_d;
      trfc_q     <= trfc_d;
      pins_q     <= pins_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      open_row_q <= open_row_d;
      err_q      <= err_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = pins_q;
  assign ba          = ba_q;
  assign addr        = addr_q;
  assign o_bank_open = (state_q == ST_OPEN);
  assign o_open_row  = open_row_q;
  assign o_cmd_err   = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_phy_cmd_issue.sv
// Directed bench for phy_cmd_issue: timing windows, pin encodings, drop/error
// handling and reset behaviour with hand-computed expectations.
module tb_phy_cmd_issue;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;
  localparam logic [2:0] C_RSV = 3'd7;

  logic        clk;
  logic        rst;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd;
  logic [2:0]  i_ba;
  logic [15:0] i_addr;
  logic        o_cmd_ready;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [15:0] addr;
  logic        o_bank_open;
  logic [15:0] o_open_row;
  logic        o_cmd_err;
  logic [1:0]  o_dbg_state;
  logic [3:0]  pins;

  int n_checks;
  int n_fail;
  int n;
  int n_acc;
  int n_rd;
  int rd_t[4];

  assign pins = {cs_n, ras_n, cas_n, we_n};

  phy_cmd_issue dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd       (i_cmd),
    .i_ba        (i_ba),
    .i_addr      (i_addr),
    .o_cmd_ready (o_cmd_ready),
    .cs_n        (cs_n),
    .ras_n       (ras_n),
    .cas_n       (cas_n),
    .we_n        (we_n),
    .ba          (ba),
    .addr        (addr),
    .o_bank_open (o_bank_open),
    .o_open_row  (o_open_row),
    .o_cmd_err   (o_cmd_err),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [2:0] b, input logic [15:0] a);
    i_cmd_valid = v;
    i_cmd       = c;
    i_ba        = b;
    i_addr      = a;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until o_cmd_ready is high; n returns the cycles waited.
  task automatic wait_ready(input int limit);
    n = 0;
    #1;
    while (!o_cmd_ready && n < limit) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b1, C_NOP, 3'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_pins", pins, 4'b1111);
    check("reset_ba", ba, 3'd0);
    check("reset_addr", addr, 16'd0);
    check("reset_bank_open", o_bank_open, 1'b0);
    check("reset_open_row", o_open_row, 16'd0);
    check("reset_err", o_cmd_err, 1'b0);
    check("reset_ready", o_cmd_ready, 1'b0);
    rst = 1'b0;
    cycle();
    check("idle_pins_nop", pins, 4'b0111);

    // ACT row 0x1234 bank 2
    drive(1'b1, C_ACT, 3'd2, 16'h1234);
    #1;
    check("act_ready", o_cmd_ready, 1'b1);
    cycle();
    check("act_pins", pins, 4'b0011);
    check("act_ba", ba, 3'd2);
    check("act_addr", addr, 16'h1234);
    check("act_bank_open", o_bank_open, 1'b1);
    check("act_open_row", o_open_row, 16'h1234);

    // RD held valid: accepted tRCD = 6 edges after the ACT
    drive(1'b1, C_RD, 3'd2, 16'hFFFF);
    wait_ready(20);
    check("rd_trcd_spacing", n + 1, 6);
    cycle();
    check("rd_pins", pins, 4'b0101);
    check("rd_addr", addr, 16'hFBFF);
    check("rd_ba", ba, 3'd2);

    // WR after RD: tCCD spacing
    drive(1'b1, C_WR, 3'd2, 16'h0010);
    wait_ready(20);
    check("wr_tccd_spacing", n + 1, 4);
    cycle();
    check("wr_pins", pins, 4'b0100);
    check("wr_addr", addr, 16'h1010);

    // PRE gated by tWTP (12 after WR, later than tRAS from ACT)
    drive(1'b1, C_PRE, 3'd2, 16'hFFFF);
    wait_ready(30);
    check("pre_twtp_spacing", n + 1, 12);
    cycle();
    check("pre_pins", pins, 4'b0010);
    check("pre_addr10", addr[10], 1'b0);
    check("pre_ba", ba, 3'd2);
    check("pre_bank_closed", o_bank_open, 1'b0);
    drive(1'b0, C_NOP, 3'd0, 16'd0);
    cycle();
    check("post_pre_nop", pins, 4'b0111);

    // RD while CLOSED: accepted, dropped, one-cycle error
    drive(1'b1, C_RD, 3'd1, 16'h00AA);
    #1;
    check("bad_rd_ready", o_cmd_ready, 1'b1);
    cycle();
    check("bad_rd_pins", pins, 4'b0111);
    check("bad_rd_err", o_cmd_err, 1'b1);
    drive(1'b0, C_NOP, 3'd0, 16'd0);
    cycle();
    check("bad_rd_err_clear", o_cmd_err, 1'b0);

    // Reserved code while CLOSED
    drive(1'b1, C_RSV, 3'd3, 16'h5555);
    #1;
    check("rsv_ready", o_cmd_ready, 1'b1);
    cycle();
    check("rsv_pins", pins, 4'b0111);
    check("rsv_err", o_cmd_err, 1'b1);

    // REF then ACT: ACT accepted exactly tRFC = 64 edges after REF
    drive(1'b1, C_REF, 3'd0, 16'd0);
    wait_ready(20);
    cycle();
    check("ref_pins", pins, 4'b0001);
    check("ref_err_clear", o_cmd_err, 1'b0);
    drive(1'b1, C_ACT, 3'd1, 16'h0042);
    wait_ready(100);
    check("act_trfc_spacing", n + 1, 64);
    cycle();
    check("act2_pins", pins, 4'b0011);
    check("act2_addr", addr, 16'h0042);
    check("act2_ba", ba, 3'd1);

    // ACT while OPEN: dropped with error, open row kept
    drive(1'b1, C_ACT, 3'd1, 16'h0777);
    #1;
    check("bad_act_ready", o_cmd_ready, 1'b1);
    cycle();
    check("bad_act_pins", pins, 4'b0111);
    check("bad_act_err", o_cmd_err, 1'b1);
    check("bad_act_row", o_open_row, 16'h0042);

    // Four back-to-back RDs: pin commands spaced tCCD = 4
    drive(1'b1, C_RD, 3'd1, 16'h0100);
    #1;
    n_acc = 0;
    n_rd  = 0;
    for (int c = 0; c < 60 && n_rd < 4; c++) begin
      if (o_cmd_ready) n_acc++;
      cycle();
      if (n_acc == 4) i_cmd_valid = 1'b0;
      if (pins == 4'b0101) begin
        rd_t[n_rd] = c;
        n_rd++;
      end
    end
    check("rd4_count", n_rd, 4);
    check("rd4_gap0", rd_t[1] - rd_t[0], 4);
    check("rd4_gap1", rd_t[2] - rd_t[1], 4);
    check("rd4_gap2", rd_t[3] - rd_t[2], 4);

    // Reset in the middle of REFRESH
    drive(1'b1, C_PRE, 3'd1, 16'd0);
    wait_ready(40);
    cycle();
    check("pre2_pins", pins, 4'b0010);
    drive(1'b1, C_REF, 3'd0, 16'd0);
    wait_ready(20);
    cycle();
    check("ref2_pins", pins, 4'b0001);
    drive(1'b1, C_ACT, 3'd4, 16'hBEEF);
    repeat (10) cycle();
    check("refresh_act_blocked", o_cmd_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("midref_reset_pins", pins, 4'b1111);
    check("midref_reset_ready", o_cmd_ready, 1'b0);
    cycle();
    rst = 1'b0;
    #1;
    check("post_reset_act_ready", o_cmd_ready, 1'b1);
    cycle();
    check("post_reset_act_pins", pins, 4'b0011);
    check("post_reset_act_row", o_open_row, 16'hBEEF);
    drive(1'b0, C_NOP, 3'd0, 16'd0);
    cycle();
    check("final_nop", pins, 4'b0111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_cmd_issue.md
PHY_CMD_ISSUE -- requirements
Module: phy_cmd_issue

Interface
REQ-001 SHALL have parameter T_RCD, default 6: minimum cycles from ACT issue to RD/WR issue.
REQ-002 SHALL have parameter T_RP, default 6: minimum cycles from PRE issue to ACT/REF issue.
REQ-003 SHALL have parameter T_RAS, default 15: minimum cycles from ACT issue to PRE issue.
REQ-004 SHALL have parameter T_CCD, default 4: minimum cycles between RD/WR issues.
REQ-005 SHALL have parameter T_WTP, default 12: minimum cycles from WR issue to PRE issue.
REQ-006 SHALL have parameter T_RFC, default 64: minimum cycles from REF issue to any command.
REQ-007 SHALL have ports clk (in, 1, sole clock, rising edge) and rst (in, 1, asynchronous active-high reset).
REQ-008 SHALL have i_cmd_valid (in, 1): a command is offered.
REQ-009 SHALL have i_cmd (in, 3): command code, 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6-7 reserved.
REQ-010 SHALL have i_ba (in, 3) and i_addr (in, 16): bank, and row (ACT) or column (RD/WR).
REQ-011 SHALL have o_cmd_ready (out, 1): offered command is accepted this cycle.
REQ-012 SHALL have DRAM pins cs_n, ras_n, cas_n, we_n (out, 1 each), ba (out, 3), addr (out, 16), all registered.
REQ-013 SHALL have o_bank_open (out, 1), o_open_row (out, 16) and o_cmd_err (out, 1, one-cycle pulse).

Function
REQ-014 SHALL accept a command on a rising edge where i_cmd_valid && o_cmd_ready.
REQ-015 SHALL compute o_cmd_ready combinationally from i_cmd, bank state and timers; it SHALL NOT depend on any other handshake.
REQ-016 SHALL track state as CLOSED, OPEN or REFRESH.
REQ-017 ACT SHALL be ready only in CLOSED with the tRP timer expired; on accept it SHALL go to OPEN and latch i_addr into o_open_row.
REQ-018 RD/WR SHALL be ready only in OPEN with the tRCD and tCCD timers expired.
REQ-019 PRE SHALL be ready in OPEN with the tRAS and tWTP timers expired; on accept it SHALL go to CLOSED.
REQ-020 PRE SHALL be ready in CLOSED after tRP expires; it issues as a legal no-op PRE with no state change.
REQ-021 REF SHALL be ready only in CLOSED with tRP expired; on accept it SHALL go to REFRESH.
REQ-022 REFRESH SHALL return to CLOSED when the tRFC timer expires; no command is ready in REFRESH.
REQ-023 RD/WR offered in CLOSED, ACT/REF offered in OPEN, and reserved codes SHALL be accepted (ready=1), dropped with pins held at NOP, and pulse o_cmd_err for one cycle starting the cycle after acceptance.
REQ-024 NOP SHALL always be ready and SHALL drive NOP.
REQ-025 Each timer SHALL be a saturating down-counter, loaded with (param-1) on issue of its trigger command, where expired means the counter is 0.
REQ-026 On any ACT, the tRAS timer SHALL be loaded; T_CCD likewise on RD/WR, and T_WTP only on WR.
REQ-027 An accepted command SHALL appear on the pins exactly one cycle after acceptance and last one cycle; pins SHALL otherwise be NOP.
REQ-028 Pin encodings (cs_n, ras_n, cas_n, we_n) SHALL be: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001.
REQ-029 ACT SHALL drive addr=i_addr; RD/WR SHALL drive addr={i_addr[15:13], 1'b1 (BL8), i_addr[11], 1'b0 (no auto-precharge), i_addr[9:0]}.
REQ-030 PRE SHALL drive addr[10]=0; ba SHALL equal i_ba for all non-NOP commands and 0 for NOP.
REQ-031 With back-to-back valid commands, consecutive RD/WR SHALL be spaced exactly T_CCD cycles on the pins.

Reset
REQ-032 While rst=1, outputs SHALL be: cs_n=1, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0, o_bank_open=0, o_open_row=0, o_cmd_err=0.
REQ-033 Reset SHALL put the state in CLOSED with all timers at 0.
REQ-034 Reset asserted mid-timer or in REFRESH SHALL abort immediately with no residual command on the pins.
REQ-035 o_cmd_ready SHALL be 0 while rst=1.

Verification
REQ-036 Reset, then ACT row 0x1234 bank 2 -> next cycle pins 0011, ba=2, addr=0x1234; o_bank_open=1; o_open_row=0x1234.
REQ-037 RD held valid right after ACT -> ready rises exactly T_RCD=6 cycles after ACT acceptance; RD on pins has addr[12]=1 and addr[10]=0.
REQ-038 WR then PRE held valid -> PRE accepted after max(T_RAS from ACT, T_WTP=12 from WR); pins 0010, addr[10]=0; o_bank_open=0.
REQ-039 RD offered while CLOSED -> accepted, pins stay NOP, o_cmd_err pulses for one cycle.
REQ-040 REF then ACT -> ACT ready exactly T_RFC=64 cycles after REF acceptance; rst pulse mid-REFRESH -> CLOSED and ACT ready on the first cycle after release.
REQ-041 Four RD back-to-back -> pin RD commands spaced exactly 4 cycles.
